// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Round-robin arbiter that shares one single-port synchronous memory between
//   port 0 (CPU sequence control) and port 1 (program loader / debug).
//   Each grant covers exactly one memory access and walks the fixed sequence
//   Idle -> Access -> Wait -> Release, so one access takes four cycles.
//
// Ports
//   Clk, Reset          : rising-edge clock, asynchronous active-low reset
//   Pn_Req/Wr/Addr/WData: request level, direction (1=write), address, data
//   Pn_Gnt              : port n owns the memory (Access through Release)
//   Pn_Ack, Pn_RData    : one-cycle completion pulse, read data valid with Ack
//   MEM_En, MEM_Wr      : memory enable (active low), write strobe (active low)
//   MEM_Addr, MEM_DIn   : registered address and write data
//   MEM_DOut            : memory read data, valid the cycle after the enabled edge
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 10
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 P0_Req,
  input  logic                 P0_Wr,
  input  logic [AddrWidth-1:0] P0_Addr,
  input  logic [DataWidth-1:0] P0_WData,
  output logic                 P0_Gnt,
  output logic                 P0_Ack,
  output logic [DataWidth-1:0] P0_RData,
  input  logic                 P1_Req,
  input  logic                 P1_Wr,
  input  logic [AddrWidth-1:0] P1_Addr,
  input  logic [DataWidth-1:0] P1_WData,
  output logic                 P1_Gnt,
  output logic                 P1_Ack,
  output logic [DataWidth-1:0] P1_RData,
  output logic                 MEM_En,
  output logic                 MEM_Wr,
  output logic [AddrWidth-1:0] MEM_Addr,
  output logic [DataWidth-1:0] MEM_DIn,
  input  logic [DataWidth-1:0] MEM_DOut
);

  typedef enum logic [1:0] {
    S_Idle    = 2'd0,
    S_Access  = 2'd1,
    S_Wait    = 2'd2,
    S_Release = 2'd3
  } state_t;

  state_t                 state_r, state_s;
  logic                   last_grant_r, last_grant_s;
  logic                   winner_r, winner_s;   // port owning the current access
  logic                   wr_r, wr_s;           // latched direction of the current access
  logic                   mem_en_r, mem_en_s;
  logic                   mem_wr_r, mem_wr_s;
  logic [AddrWidth-1:0]   mem_addr_r, mem_addr_s;
  logic [DataWidth-1:0]   mem_din_r, mem_din_s;
  logic                   gnt0_r, gnt0_s, gnt1_r, gnt1_s;
  logic                   ack0_r, ack0_s, ack1_r, ack1_s;
  logic [DataWidth-1:0]   rdata0_r, rdata0_s, rdata1_r, rdata1_s;
  logic                   req_any_s;
  logic                   pick_s;

  // Round-robin pick: on a tie the port that did not win last time goes next.
  always_comb begin
    req_any_s = P0_Req | P1_Req;
    pick_s    = 1'b0;
    if (P0_Req && P1_Req) begin
      pick_s = ~last_grant_r;
    end else if (P1_Req) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    winner_s     = winner_r;
    wr_s         = wr_r;
    mem_en_s     = mem_en_r;
    mem_wr_s     = mem_wr_r;
    mem_addr_s   = mem_addr_r;
    mem_din_s    = mem_din_r;
    gnt0_s       = gnt0_r;
    gnt1_s       = gnt1_r;
    ack0_s       = ack0_r;
    ack1_s       = ack1_r;
    rdata0_s     = rdata0_r;
    rdata1_s     = rdata1_r;
    case (state_r)
      S_Idle: begin
        if (req_any_s) begin
          // Request fields are captured here; later changes are ignored.
          winner_s     = pick_s;
          last_grant_s = pick_s;
          gnt0_s       = ~pick_s;
          gnt1_s       = pick_s;
          mem_addr_s   = pick_s ? P1_Addr  : P0_Addr;
          mem_din_s    = pick_s ? P1_WData : P0_WData;
          wr_s         = pick_s ? P1_Wr    : P0_Wr;
          mem_wr_s     = ~(pick_s ? P1_Wr : P0_Wr);
          mem_en_s     = 1'b0;
          state_s      = S_Access;
        end else begin
          state_s = S_Idle;
        end
      end
      S_Access: begin
        // The memory samples at the edge closing this cycle.
        mem_en_s = 1'b1;
        mem_wr_s = 1'b1;
        state_s  = S_Wait;
      end
      S_Wait: begin
        if (winner_r) begin
          ack1_s = 1'b1;
          if (!wr_r) begin
            rdata1_s = MEM_DOut;
          end else begin
            rdata1_s = rdata1_r;
          end
        end else begin
          ack0_s = 1'b1;
          if (!wr_r) begin
            rdata0_s = MEM_DOut;
          end else begin
            rdata0_s = rdata0_r;
          end
        end
        state_s = S_Release;
      end
      S_Release: begin
        ack0_s  = 1'b0;
        ack1_s  = 1'b0;
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        state_s = S_Idle;
      end
      default: begin
        // Unreachable encoding: drop all strobes and recover to idle.
        mem_en_s = 1'b1;
        mem_wr_s = 1'b1;
        gnt0_s   = 1'b0;
        gnt1_s   = 1'b0;
        ack0_s   = 1'b0;
        ack1_s   = 1'b0;
        state_s  = S_Idle;
      end
    endcase
  end

  // State and output registers; reset aborts any access and releases the memory.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r      <= S_Idle;
      last_grant_r <= 1'b1;
      winner_r     <= 1'b0;
      wr_r         <= 1'b0;
      mem_en_r     <= 1'b1;
      mem_wr_r     <= 1'b1;
      mem_addr_r   <= {AddrWidth{1'b0}};
      mem_din_r    <= {DataWidth{1'b0}};
      gnt0_r       <= 1'b0;
      gnt1_r       <= 1'b0;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      rdata0_r     <= {DataWidth{1'b0}};
      rdata1_r     <= {DataWidth{1'b0}};
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      winner_r     <= winner_s;
      wr_r         <= wr_s;
      mem_en_r     <= mem_en_s;
      mem_wr_r     <= mem_wr_s;
      mem_addr_r   <= mem_addr_s;
      mem_din_r    <= mem_din_s;
      gnt0_r       <= gnt0_s;
      gnt1_r       <= gnt1_s;
      ack0_r       <= ack0_s;
      ack1_r       <= ack1_s;
      rdata0_r     <= rdata0_s;
      rdata1_r     <= rdata1_s;
    end
  end

  assign MEM_En   = mem_en_r;
  assign MEM_Wr   = mem_wr_r;
  assign MEM_Addr = mem_addr_r;
  assign MEM_DIn  = mem_din_r;
  assign P0_Gnt   = gnt0_r;
  assign P1_Gnt   = gnt1_r;
  assign P0_Ack   = ack0_r;
  assign P1_Ack   = ack1_r;
  assign P0_RData = rdata0_r;
  assign P1_RData = rdata1_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a behavioural synchronous memory.
//   Single-port accesses come from a vector table; tie-break alternation,
//   address change during Wait and reset mid-access are hand sequences.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        P0_Req = 1'b0, P0_Wr = 1'b0;
  logic [9:0]  P0_Addr = 10'h000;
  logic [15:0] P0_WData = 16'h0000;
  logic        P1_Req = 1'b0, P1_Wr = 1'b0;
  logic [9:0]  P1_Addr = 10'h000;
  logic [15:0] P1_WData = 16'h0000;
  logic        P0_Gnt, P0_Ack, P1_Gnt, P1_Ack;
  logic [15:0] P0_RData, P1_RData;
  logic        MEM_En, MEM_Wr;
  logic [9:0]  MEM_Addr;
  logic [15:0] MEM_DIn;
  logic [15:0] MEM_DOut = 16'h0000;

  mem_port_arbiter #(.DataWidth(16), .AddrWidth(10)) dut (
    .Clk(Clk), .Reset(Reset),
    .P0_Req(P0_Req), .P0_Wr(P0_Wr), .P0_Addr(P0_Addr), .P0_WData(P0_WData),
    .P0_Gnt(P0_Gnt), .P0_Ack(P0_Ack), .P0_RData(P0_RData),
    .P1_Req(P1_Req), .P1_Wr(P1_Wr), .P1_Addr(P1_Addr), .P1_WData(P1_WData),
    .P1_Gnt(P1_Gnt), .P1_Ack(P1_Ack), .P1_RData(P1_RData),
    .MEM_En(MEM_En), .MEM_Wr(MEM_Wr), .MEM_Addr(MEM_Addr), .MEM_DIn(MEM_DIn),
    .MEM_DOut(MEM_DOut)
  );

  always #5 Clk = ~Clk;

  // Behavioural single-port memory, preloaded on the first clock edge.
  logic [15:0] mem [1024];
  logic        mem_init_done = 1'b0;
  always @(posedge Clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
      mem[10'h005]  <= 16'hA09F;
      mem[10'h010]  <= 16'h5A5A;
      mem[10'h020]  <= 16'h0C3C;
      mem_init_done <= 1'b1;
    end else if (!MEM_En) begin
      if (!MEM_Wr) mem[MEM_Addr] <= MEM_DIn;
      MEM_DOut <= mem[MEM_Addr];
    end
  end

  typedef struct packed {
    logic        port;
    logic        wr;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;   // expected read data (reads only)
  } vec_t;

  vec_t        vecs [7];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_rd0 = 16'h0000;
  logic [15:0] exp_rd1 = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one edge, sample 1 time unit later and check grant exclusivity.
  task automatic tick();
    @(posedge Clk);
    #1;
    check("gnt_exclusive", {31'd0, P0_Gnt & P1_Gnt}, 32'd0);
  endtask

  task automatic drive(input logic port, input logic wr, input logic [9:0] addr,
                       input logic [15:0] wdata);
    if (port) begin
      P1_Req = 1'b1; P1_Wr = wr; P1_Addr = addr; P1_WData = wdata;
    end else begin
      P0_Req = 1'b1; P0_Wr = wr; P0_Addr = addr; P0_WData = wdata;
    end
  endtask

  task automatic run_access(input vec_t v);
    @(negedge Clk);
    drive(v.port, v.wr, v.addr, v.wdata);
    tick();  // S_Access
    check("acc_en",   {31'd0, MEM_En}, 32'd0);
    check("acc_wr",   {31'd0, MEM_Wr}, {31'd0, ~v.wr});
    check("acc_addr", {22'd0, MEM_Addr}, {22'd0, v.addr});
    if (v.wr) check("acc_din", {16'd0, MEM_DIn}, {16'd0, v.wdata});
    check("acc_gnt",  {30'd0, P1_Gnt, P0_Gnt}, v.port ? 32'd2 : 32'd1);
    check("acc_ack",  {30'd0, P1_Ack, P0_Ack}, 32'd0);
    tick();  // S_Wait
    check("wait_en",  {30'd0, MEM_En, MEM_Wr}, 32'd3);
    check("wait_ack", {30'd0, P1_Ack, P0_Ack}, 32'd0);
    tick();  // S_Release
    if (!v.wr) begin
      if (v.port) exp_rd1 = v.exp_rdata;
      else        exp_rd0 = v.exp_rdata;
    end
    check("rel_ack",  {30'd0, P1_Ack, P0_Ack}, v.port ? 32'd2 : 32'd1);
    check("rel_gnt",  {30'd0, P1_Gnt, P0_Gnt}, v.port ? 32'd2 : 32'd1);
    check("rel_rd0",  {16'd0, P0_RData}, {16'd0, exp_rd0});
    check("rel_rd1",  {16'd0, P1_RData}, {16'd0, exp_rd1});
    P0_Req = 1'b0; P1_Req = 1'b0;
    tick();  // S_Idle
    check("idle_out", {28'd0, P1_Gnt, P0_Gnt, P1_Ack, P0_Ack}, 32'd0);
    check("idle_en",  {31'd0, MEM_En}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b0;
    P0_Req = 1'b0; P1_Req = 1'b0;
    repeat (2) tick();
    check("rst_mem",   {30'd0, MEM_En, MEM_Wr}, 32'd3);
    check("rst_addr",  {6'd0, MEM_Addr, MEM_DIn}, 32'd0);
    check("rst_gntack",{28'd0, P1_Gnt, P0_Gnt, P1_Ack, P0_Ack}, 32'd0);
    check("rst_rdata", {P1_RData, P0_RData}, 32'd0);
    exp_rd0 = 16'h0000; exp_rd1 = 16'h0000;
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 10'h005, 16'h0000, 16'hA09F};  // p0 read preload
    vecs[1] = '{1'b1, 1'b1, 10'h3FF, 16'h1234, 16'h0000};  // p1 write top addr
    vecs[2] = '{1'b0, 1'b0, 10'h3FF, 16'h0000, 16'h1234};  // p0 reads it back
    vecs[3] = '{1'b1, 1'b0, 10'h005, 16'h0000, 16'hA09F};  // p1 read
    vecs[4] = '{1'b0, 1'b1, 10'h000, 16'hFFFF, 16'h0000};  // p0 write addr 0
    vecs[5] = '{1'b1, 1'b0, 10'h000, 16'h0000, 16'hFFFF};  // p1 reads it back
    vecs[6] = '{1'b0, 1'b0, 10'h001, 16'h0000, 16'h0000};  // p0 read unwritten

    // Reset, then idle with no requests.
    do_reset();
    repeat (3) begin
      tick();
      check("idle_hold", {28'd0, MEM_En, MEM_Wr, P0_Gnt | P1_Gnt, P0_Ack | P1_Ack}, 32'd12);
    end

    for (int i = 0; i < 7; i++) run_access(vecs[i]);

    // Both ports request together after reset: strict 0,1,0,1 alternation.
    do_reset();
    @(negedge Clk);
    drive(1'b0, 1'b0, 10'h005, 16'h0000);
    drive(1'b1, 1'b0, 10'h3FF, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      tick();  // grant edge, 4 cycles after the previous one
      check("rr_gnt",  {30'd0, P1_Gnt, P0_Gnt}, k[0] ? 32'd2 : 32'd1);
      check("rr_addr", {22'd0, MEM_Addr}, k[0] ? 32'h3FF : 32'h005);
      tick();
      tick();  // Ack cycle
      if (k[0]) exp_rd1 = 16'h1234;
      else      exp_rd0 = 16'hA09F;
      check("rr_ack",  {30'd0, P1_Ack, P0_Ack}, k[0] ? 32'd2 : 32'd1);
      check("rr_rd",   {P1_RData, P0_RData}, {exp_rd1, exp_rd0});
      if (k == 3) begin
        P0_Req = 1'b0; P1_Req = 1'b0;
      end
      tick();
      check("rr_rel",  {30'd0, P1_Gnt, P0_Gnt}, 32'd0);
    end

    // Address changed during S_Wait is ignored for the current access.
    @(negedge Clk);
    drive(1'b0, 1'b0, 10'h010, 16'h0000);
    tick();
    check("chg_addr0", {22'd0, MEM_Addr}, 32'h010);
    tick();
    P0_Addr = 10'h020;
    tick();
    exp_rd0 = 16'h5A5A;
    check("chg_ack",   {31'd0, P0_Ack}, 32'd1);
    check("chg_rd",    {16'd0, P0_RData}, {16'd0, exp_rd0});
    check("chg_addr1", {22'd0, MEM_Addr}, 32'h010);
    P0_Req = 1'b0;
    tick();
    run_access('{1'b0, 1'b0, 10'h020, 16'h0000, 16'h0C3C});

    // Reset during S_Access of a port 1 write: write is dropped, no Ack.
    @(negedge Clk);
    drive(1'b1, 1'b1, 10'h001, 16'hBEEF);
    tick();
    check("ra_en", {30'd0, MEM_En, MEM_Wr}, 32'd0);
    #2;
    Reset = 1'b0;
    #1;
    check("ra_async", {29'd0, MEM_En, MEM_Wr, P1_Gnt}, 32'd6);
    P1_Req = 1'b0;
    repeat (2) begin
      tick();
      check("ra_noack", {30'd0, P1_Ack, MEM_En}, 32'd1);
    end
    @(negedge Clk);
    Reset = 1'b1;
    exp_rd0 = 16'h0000; exp_rd1 = 16'h0000;
    run_access('{1'b0, 1'b0, 10'h001, 16'h0000, 16'h0000});

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
